// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller and its datapath muxes.
// Latency: none (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Encoding 4'd15 is unused; the next-state logic recovers it to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } srca_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_t;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } aluop_t;

  typedef struct packed {
    logic        pc_update;
    logic        branch;
    logic        reg_write;
    logic        mem_write;
    logic        ir_write;
    logic        adr_src;
    result_src_t result_src;
    srca_t       alu_src_a;
    srcb_t       alu_src_b;
    aluop_t      alu_op;
    logic        halted;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// State-to-controls table for the multicycle main FSM (Moore outputs).
// Latency: purely combinational.
// Backpressure: mem_ready only qualifies the FETCH write strobes.
module mc_outdec
  import riscv_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Every field defaults to zero; each state raises only what it needs.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_update  = mem_ready;
      end
      S_DECODE, S_AUIPC: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_JALR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = ALUOP_BRANCH;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_mainfsm.sv
// Main control FSM of the multicycle RISC-V core: sequences fetch/decode/execute.
// Latency: 3-5 cycles per instruction with mem_ready high; outputs are Moore.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold one extra cycle per mem_ready=0.
module mc_mainfsm
  import riscv_pkg::*;
#(
  parameter int unsigned ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       halted
);

  state_t state, state_nxt;
  ctrl_t  ctrl;
  logic   mem_ready_gated;

  // State register; reset forces FETCH at once, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic; unknown encodings fall back to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BEQ;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_JALR:     state_nxt = S_JAL;
      S_JAL:      state_nxt = S_ALUWB;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // While reset is held the FETCH strobes must stay low.
  assign mem_ready_gated = mem_ready & ~reset;

  mc_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready_gated),
    .ctrl      (ctrl)
  );

  assign PCUpdate  = ctrl.pc_update;
  assign Branch    = ctrl.branch;
  assign RegWrite  = ctrl.reg_write;
  assign MemWrite  = ctrl.mem_write;
  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_mc_mainfsm.sv
// Bench for mc_mainfsm: vector table, directed corner sequences, random run vs model.
// Latency: n/a.
// Backpressure: mem_ready is driven randomly in the random phase.
module tb_mc_mainfsm;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011,
                         T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111,
                         T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

  // Output word: {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,halted}
  localparam logic [14:0] V_DEC   = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_MADR  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_MRD   = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MWB   = {6'b001000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_MWR   = {6'b000101, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_EXR   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
  localparam logic [14:0] V_EXI   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
  localparam logic [14:0] V_WB    = {6'b001000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [14:0] V_BEQ   = {6'b010000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
  localparam logic [14:0] V_JALR  = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_JAL   = {6'b100000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
  localparam logic [14:0] V_LUI   = {6'b000000, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_AUIPC = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
  localparam logic [14:0] V_HALT  = 15'd1;

  typedef enum {M_FETCH, M_DEC, M_MADR, M_MRD, M_MWB, M_MWR, M_EXR, M_EXI, M_WB,
                M_BEQ, M_JAL, M_JALR, M_LUI, M_AUIPC, M_HALT} step_t;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [14:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic mem_ready = 1'b1;

  logic PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic PCUpdate0, Branch0, RegWrite0, MemWrite0, IRWrite0, AdrSrc0, halted0;
  logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ALUOp0;
  logic [14:0] out1, out0;

  int checks = 0;
  int errors = 0;
  step_t cur;
  step_t plan[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  mc_mainfsm #(.ILLEGAL_TRAP(1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .halted(halted)
  );

  mc_mainfsm #(.ILLEGAL_TRAP(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate0), .Branch(Branch0), .RegWrite(RegWrite0), .MemWrite(MemWrite0),
    .IRWrite(IRWrite0), .AdrSrc(AdrSrc0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0), .halted(halted0)
  );

  assign out1 = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, halted};
  assign out0 = {PCUpdate0, Branch0, RegWrite0, MemWrite0, IRWrite0, AdrSrc0,
                 ResultSrc0, ALUSrcA0, ALUSrcB0, ALUOp0, halted0};

  function automatic logic [14:0] fetch_v(input logic mr);
    return {mr, 1'b0, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
  endfunction

  function automatic logic [14:0] step_out(input step_t s, input logic mr);
    case (s)
      M_FETCH: return fetch_v(mr);
      M_DEC:   return V_DEC;
      M_MADR:  return V_MADR;
      M_MRD:   return V_MRD;
      M_MWB:   return V_MWB;
      M_MWR:   return V_MWR;
      M_EXR:   return V_EXR;
      M_EXI:   return V_EXI;
      M_WB:    return V_WB;
      M_BEQ:   return V_BEQ;
      M_JAL:   return V_JAL;
      M_JALR:  return V_JALR;
      M_LUI:   return V_LUI;
      M_AUIPC: return V_AUIPC;
      default: return V_HALT;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC};
  endfunction

  function automatic logic [6:0] pick_op();
    logic [6:0] legal [9];
    logic [6:0] o;
    legal = '{T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC};
    if ($urandom_range(0, 11) == 0) begin
      o = 7'($urandom);
      while (is_legal(o)) o = 7'($urandom);
      return o;
    end
    return legal[$urandom_range(0, 8)];
  endfunction

  task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic apply(input logic [6:0] o, input logic mr, input logic [14:0] exp, input string nm);
    @(negedge clk);
    op = o;
    mem_ready = mr;
    #1;
    check(nm, out1, exp);
  endtask

  // mid=1: reset rises between clock edges (called 1 time unit after a negedge).
  task automatic do_reset(input bit mid);
    if (mid) #2;
    else @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_hold", out1, fetch_v(1'b0));
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_release", out1, fetch_v(1'b0));
  endtask

  // Micro-step list each instruction class runs after DECODE.
  task automatic build_plan(input logic [6:0] o);
    plan.delete();
    case (o)
      T_LOAD:  begin plan.push_back(M_MADR); plan.push_back(M_MRD); plan.push_back(M_MWB); end
      T_STORE: begin plan.push_back(M_MADR); plan.push_back(M_MWR); end
      T_R:     begin plan.push_back(M_EXR); plan.push_back(M_WB); end
      T_I:     begin plan.push_back(M_EXI); plan.push_back(M_WB); end
      T_BR:    plan.push_back(M_BEQ);
      T_JAL:   begin plan.push_back(M_JAL); plan.push_back(M_WB); end
      T_JALR:  begin plan.push_back(M_JALR); plan.push_back(M_JAL); plan.push_back(M_WB); end
      T_LUI:   begin plan.push_back(M_LUI); plan.push_back(M_WB); end
      T_AUIPC: begin plan.push_back(M_AUIPC); plan.push_back(M_WB); end
      default: plan.push_back(M_HALT);
    endcase
  endtask

  task automatic next_step();
    if (plan.size() > 0) cur = plan.pop_front();
    else cur = M_FETCH;
  endtask

  task automatic advance(input logic mr);
    case (cur)
      M_FETCH: if (mr) cur = M_DEC;
      M_DEC:   begin build_plan(op); next_step(); end
      M_MRD, M_MWR: if (mr) next_step();
      M_HALT:  cur = M_HALT;
      default: next_step();
    endcase
  endtask

  initial begin
    int mw_cnt;
    int halt_n;
    logic mr;

    // Reset held with mem_ready high: FETCH values with strobes masked.
    #1;
    check("reset_state", out1, fetch_v(1'b0));
    do_reset(1'b0);

    // Table: FETCH wait (2 cycles), load, jalr, branch.
    tbl.push_back('{T_LOAD, 1'b0, fetch_v(1'b0)});
    tbl.push_back('{T_LOAD, 1'b0, fetch_v(1'b0)});
    tbl.push_back('{T_LOAD, 1'b1, fetch_v(1'b1)});
    tbl.push_back('{T_LOAD, 1'b1, V_DEC});
    tbl.push_back('{T_LOAD, 1'b1, V_MADR});
    tbl.push_back('{T_LOAD, 1'b1, V_MRD});
    tbl.push_back('{T_LOAD, 1'b1, V_MWB});
    tbl.push_back('{T_JALR, 1'b1, fetch_v(1'b1)});
    tbl.push_back('{T_JALR, 1'b1, V_DEC});
    tbl.push_back('{T_JALR, 1'b1, V_JALR});
    tbl.push_back('{T_JALR, 1'b1, V_JAL});
    tbl.push_back('{T_JALR, 1'b1, V_WB});
    tbl.push_back('{T_BR,   1'b1, fetch_v(1'b1)});
    tbl.push_back('{T_BR,   1'b1, V_DEC});
    tbl.push_back('{T_BR,   1'b1, V_BEQ});
    tbl.push_back('{T_LUI,  1'b1, fetch_v(1'b1)});
    tbl.push_back('{T_LUI,  1'b1, V_DEC});
    tbl.push_back('{T_LUI,  1'b1, V_LUI});
    tbl.push_back('{T_LUI,  1'b1, V_WB});
    tbl.push_back('{T_LUI,  1'b0, fetch_v(1'b0)});
    foreach (tbl[i]) apply(tbl[i].op, tbl[i].mr, tbl[i].exp, $sformatf("tbl%0d", i));

    // Store with three wait cycles: MemWrite held 4 cycles, then FETCH.
    do_reset(1'b0);
    apply(T_STORE, 1'b1, fetch_v(1'b1), "s2_fetch");
    apply(T_STORE, 1'b1, V_DEC, "s2_dec");
    apply(T_STORE, 1'b1, V_MADR, "s2_madr");
    mw_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      apply(T_STORE, (k == 3), V_MWR, "s2_mwr");
      if (MemWrite) mw_cnt++;
    end
    apply(T_STORE, 1'b0, fetch_v(1'b0), "s2_back");
    if (MemWrite) mw_cnt++;
    check("s2_mw_run", 15'(mw_cnt), 15'd4);

    // Illegal opcode: trap version halts for good, non-trap version refetches.
    do_reset(1'b0);
    apply(7'b1111111, 1'b1, fetch_v(1'b1), "s4_fetch");
    apply(7'b1111111, 1'b1, V_DEC, "s4_dec");
    check("s4_dec_nt", out0, V_DEC);
    for (int k = 0; k < 10; k++) begin
      mr = 1'($urandom);
      apply(7'b1111111, mr, V_HALT, "s4_halt");
      if (k == 0) check("s4_nt_fetch", out0, fetch_v(mr));
    end
    do_reset(1'b1);

    // Asynchronous reset mid-cycle while MemWrite is asserted.
    apply(T_STORE, 1'b1, fetch_v(1'b1), "s5_fetch");
    apply(T_STORE, 1'b1, V_DEC, "s5_dec");
    apply(T_STORE, 1'b1, V_MADR, "s5_madr");
    apply(T_STORE, 1'b0, V_MWR, "s5_mwr");
    #2;
    reset = 1'b1;
    #1;
    check("s5_memwrite_drop", {14'd0, MemWrite}, 15'd0);
    check("s5_fetch_vals", out1, fetch_v(1'b0));
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    apply(T_R, 1'b1, fetch_v(1'b1), "s5_refetch");
    apply(T_R, 1'b1, V_DEC, "s5_r_dec");
    apply(T_R, 1'b1, V_EXR, "s5_r_exr");
    apply(T_R, 1'b1, V_WB, "s5_r_wb");
    apply(T_I, 1'b1, fetch_v(1'b1), "i_fetch");
    apply(T_I, 1'b1, V_DEC, "i_dec");
    apply(T_I, 1'b1, V_EXI, "i_exi");
    apply(T_AUIPC, 1'b1, V_WB, "i_wb");

    // Random run against the step-list model.
    do_reset(1'b0);
    cur = M_FETCH;
    plan.delete();
    halt_n = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (cur == M_FETCH) op = pick_op();
      mem_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rand", out1, step_out(cur, mem_ready));
      if (cur == M_HALT) halt_n++;
      if (halt_n > 3 || $urandom_range(0, 59) == 0) begin
        do_reset(1'b1);
        cur = M_FETCH;
        plan.delete();
        halt_n = 0;
      end else begin
        advance(mem_ready);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_mainfsm.md
MC_MAINFSM -- requirements
Module: mc_mainfsm

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 1, meaning 1 = unknown opcode enters HALT and 0 = unknown opcode returns to FETCH as a NOP.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port op  input  7  opcode field of the instruction register.
REQ-005 SHALL have port mem_ready  input  1  unified memory has completed the current access this cycle.
REQ-006 SHALL have ports PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc  output  1 each  datapath strobes and address select (AdrSrc: 0 = PC, 1 = ALUOut).
REQ-007 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB, ALUOp  output  2 each.
- ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA: 00 PC, 01 OldPC, 10 RD1, 11 zero.
- ALUSrcB: 00 RD2, 01 ImmExt, 10 constant 4.
- ALUOp: 00 add, 01 branch compare, 10 funct-decoded.
REQ-008 SHALL have port halted  output  1  high while in HALT.

Function
REQ-009 SHALL be a Moore FSM with 15 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALR, LUI, AUIPC, HALT.
REQ-010 SHALL drive every output as a function of the current state only; any output not listed for a state is 0 (selects 00).
REQ-011 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- IRWrite=PCUpdate=mem_ready; this is the only output qualified by an input.
- Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
REQ-012 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
- Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
- Any other op -> HALT if ILLEGAL_TRAP=1, else FETCH.
REQ-013 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00; op=0000011 -> MEMREAD, otherwise -> MEMWRITE.
REQ-014 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00; holds until mem_ready=1, then -> MEMWB.
REQ-015 MEMWB SHALL drive ResultSrc=01, RegWrite=1; -> FETCH.
REQ-016 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1.
- MemWrite stays asserted continuously until mem_ready=1, then -> FETCH.
REQ-017 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; -> ALUWB.
REQ-018 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; -> ALUWB.
REQ-019 LUI SHALL drive ALUSrcA=11, ALUSrcB=01, ALUOp=00; -> ALUWB.
REQ-020 AUIPC SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00; -> ALUWB.
REQ-021 ALUWB SHALL drive ResultSrc=00, RegWrite=1; -> FETCH.
REQ-022 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
REQ-023 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00 (rs1+imm into ALUOut); -> JAL.
REQ-024 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB (rd = OldPC+4).
REQ-025 HALT SHALL drive halted=1 with all other outputs 0, and remain in HALT until reset.
REQ-026 Instruction latency with mem_ready tied high SHALL be:
- 5 cycles: load.
- 4 cycles: store, R-type, I-type, jal, lui, auipc.
- 3 cycles: branch.
- 5 cycles: jalr.
REQ-027 Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle of latency, with no strobe duplicated.
REQ-028 A state register value outside the 15 encodings SHALL transition to FETCH on the next clock.

Reset
REQ-029 Asserting reset SHALL force state to FETCH immediately, without waiting for a clock edge, including mid-instruction and while in HALT.
REQ-030 While reset is high, outputs SHALL equal the FETCH values with mem_ready masked to 0: all strobes 0, ALUSrcB=10, ResultSrc=10, halted=0.
REQ-031 The first FETCH SHALL begin on the first rising clk edge after reset deasserts.

Structure
REQ-032 Opcode constants, the state encoding and the mux-select encodings SHALL live in shared package riscv_pkg, also used by the datapath muxes.
REQ-033 The state-to-controls table SHALL be one combinational sub-module, mc_outdec; next-state logic and the state register stay in mc_mainfsm.
REQ-034 The existing ALU decoder and immediate decoder SHALL remain separate blocks, instantiated beside this one in the controller.

Verification
REQ-035 Scenario 1: mem_ready=1, op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5.
REQ-036 Scenario 2: op=0100011, mem_ready low for 3 cycles in MEMWRITE -> MemWrite high for exactly 4 consecutive cycles, then FETCH.
REQ-037 Scenario 3: op=1100111 -> DECODE, JALR, JAL, ALUWB; PCUpdate=1 in JAL with ResultSrc=00; RegWrite=1 in ALUWB.
REQ-038 Scenario 4: op=1111111, ILLEGAL_TRAP=1 -> HALT after DECODE, halted=1, all strobes 0 for 10 cycles; with ILLEGAL_TRAP=0 -> FETCH.
REQ-039 Scenario 5: reset pulsed asynchronously between clock edges while in MEMWRITE -> MemWrite falls before the next edge and state = FETCH.
REQ-040 Scenario 6: mem_ready=0 for 2 cycles in FETCH -> IRWrite and PCUpdate stay 0 for 2 cycles, then go high for exactly 1 cycle.
